// File: rtl/aska_npg_pulse_shaper.sv
// Biphasic pulse shaper for the ASKA neural pulse generator: one start strobe launches
// cathodic phase, optional inter-phase gap, anodic phase and electrode discharge.
module aska_npg_pulse_shaper #(
  parameter int AMP_W     = 6,
  parameter int PH_W      = 3,
  parameter int STEP_W    = 4,
  parameter int DISCH_CYC = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pulse_start,
  input  logic [PH_W-1:0]   phase_duration,
  input  logic [PH_W-1:0]   ipg,
  input  logic [AMP_W-1:0]  ramp,
  input  logic [STEP_W-1:0] up,
  input  logic [STEP_W-1:0] down,
  input  logic              enable,
  output logic [AMP_W-1:0]  dac_code,
  output logic [AMP_W-1:0]  amp_level,
  output logic              sw_cath,
  output logic              sw_anod,
  output logic              sw_short,
  output logic              busy,
  output logic              ramp_done,
  output logic              overrun,
  output logic [2:0]        dbg_state
);

  // The discharge count may need more bits than the phase counters.
  localparam int DW    = $clog2(DISCH_CYC + 1);
  localparam int CNT_W = (DW > PH_W) ? DW : PH_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CATH  = 3'd1,
    GAP   = 3'd2,
    ANOD  = 3'd3,
    DISCH = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [PH_W-1:0]    pd_q, ipg_q;
  logic [AMP_W:0]     sum;
  logic [AMP_W-1:0]   amp_upd, amp_nxt;
  logic               start_ok;

  assign start_ok  = pulse_start && (state == IDLE);
  assign dbg_state = state;

  // Amplitude update: saturating ramp up toward the target, saturating ramp down to zero.
  always_comb begin
    sum = {1'b0, amp_level} + (AMP_W + 1)'(up);
    if (enable)
      amp_upd = (sum > {1'b0, ramp}) ? ramp : sum[AMP_W-1:0];
    else
      amp_upd = (amp_level > AMP_W'(down)) ? amp_level - AMP_W'(down) : '0;
    amp_nxt = start_ok ? amp_upd : amp_level;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pulse_start) state_nxt = (amp_upd != '0) ? CATH : IDLE;
      CATH:  if (cnt == CNT_W'(pd_q)) state_nxt = (ipg_q != '0) ? GAP : ANOD;
      GAP:   if (cnt == CNT_W'(ipg_q) - CNT_W'(1)) state_nxt = ANOD;
      ANOD:  if (cnt == CNT_W'(pd_q)) state_nxt = DISCH;
      DISCH: if (cnt == CNT_W'(DISCH_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      pd_q      <= '0;
      ipg_q     <= '0;
      amp_level <= '0;
      dac_code  <= '0;
      sw_cath   <= 1'b0;
      sw_anod   <= 1'b0;
      sw_short  <= 1'b1;
      busy      <= 1'b0;
      ramp_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state_nxt == IDLE))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (start_ok) begin
        pd_q  <= phase_duration;
        ipg_q <= ipg;
      end
      amp_level <= amp_nxt;
      dac_code  <= ((state_nxt == CATH) || (state_nxt == ANOD)) ? amp_nxt : '0;
      sw_cath   <= (state_nxt == CATH);
      sw_anod   <= (state_nxt == ANOD);
      sw_short  <= (state_nxt == IDLE) || (state_nxt == DISCH);
      busy      <= (state_nxt != IDLE);
      ramp_done <= enable && (amp_nxt == ramp);
      overrun   <= pulse_start && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_aska_npg_pulse_shaper.sv
// Bench for aska_npg_pulse_shaper: expected pulses queued at start, checked by a
// waveform monitor that measures phase lengths and DAC codes.
module tb_aska_npg_pulse_shaper;

  localparam int AMP_W = 6;
  localparam int PH_W = 3;
  localparam int STEP_W = 4;
  localparam int DISCH_CYC = 4;

  logic              clk;
  logic              resetn;
  logic              pulse_start;
  logic [PH_W-1:0]   phase_duration;
  logic [PH_W-1:0]   ipg;
  logic [AMP_W-1:0]  ramp;
  logic [STEP_W-1:0] up;
  logic [STEP_W-1:0] down;
  logic              enable;
  logic [AMP_W-1:0]  dac_code;
  logic [AMP_W-1:0]  amp_level;
  logic              sw_cath, sw_anod, sw_short, busy, ramp_done, overrun;
  logic [2:0]        dbg_state;

  aska_npg_pulse_shaper #(
    .AMP_W(AMP_W), .PH_W(PH_W), .STEP_W(STEP_W), .DISCH_CYC(DISCH_CYC)
  ) dut (
    .clk(clk), .resetn(resetn), .pulse_start(pulse_start),
    .phase_duration(phase_duration), .ipg(ipg), .ramp(ramp), .up(up), .down(down),
    .enable(enable), .dac_code(dac_code), .amp_level(amp_level), .sw_cath(sw_cath),
    .sw_anod(sw_anod), .sw_short(sw_short), .busy(busy), .ramp_done(ramp_done),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard
  logic [AMP_W-1:0] exp_q[$];
  int pd_q[$];
  int ipg_q[$];
  int model_amp = 0;

  // monitor: 0 idle, 1 cath, 2 gap, 3 anod, 4 disch
  int mon_ph = 0;
  int run = 0;
  int cur_amp = 0, cur_pd = 0, cur_ipg = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      mon_ph = 0;
      run = 0;
    end else begin
      check("sw_excl", int'($countones({sw_cath, sw_anod, sw_short}) > 1), 0);
      case (mon_ph)
        0: if (sw_cath) begin
             check("pulse_expected", int'(exp_q.size() != 0), 1);
             if (exp_q.size() != 0) begin
               cur_amp = int'(exp_q.pop_front());
               cur_pd = pd_q.pop_front();
               cur_ipg = ipg_q.pop_front();
             end
             check("dac_cath", int'(dac_code), cur_amp);
             mon_ph = 1;
             run = 1;
           end
        1: if (sw_cath) begin
             run++;
             check("dac_cath", int'(dac_code), cur_amp);
           end else begin
             check("cath_len", run, cur_pd + 1);
             if (sw_anod) begin
               check("gap_len", 0, cur_ipg);
               check("dac_anod", int'(dac_code), cur_amp);
               mon_ph = 3;
             end else begin
               check("gap_dac", int'(dac_code), 0);
               check("gap_short", int'(sw_short), 0);
               mon_ph = 2;
             end
             run = 1;
           end
        2: if (sw_anod) begin
             check("gap_len", run, cur_ipg);
             check("dac_anod", int'(dac_code), cur_amp);
             mon_ph = 3;
             run = 1;
           end else begin
             run++;
             check("gap_dac", int'(dac_code), 0);
             check("gap_short", int'(sw_short), 0);
           end
        3: if (sw_anod) begin
             run++;
             check("dac_anod", int'(dac_code), cur_amp);
           end else begin
             check("anod_len", run, cur_pd + 1);
             check("disch_short", int'(sw_short && busy), 1);
             mon_ph = 4;
             run = 1;
           end
        default: if (busy) begin
             run++;
             check("disch_short", int'(sw_short), 1);
           end else begin
             check("disch_len", run, DISCH_CYC);
             mon_ph = 0;
           end
      endcase
    end
  end

  // driver tasks
  task automatic do_pulse();
    int s;
    if (enable) begin
      s = model_amp + int'(up);
      model_amp = (s > int'(ramp)) ? int'(ramp) : s;
    end else begin
      model_amp = (model_amp > int'(down)) ? model_amp - int'(down) : 0;
    end
    if (model_amp != 0) begin
      exp_q.push_back(AMP_W'(model_amp));
      pd_q.push_back(int'(phase_duration));
      ipg_q.push_back(int'(ipg));
    end
    @(negedge clk);
    pulse_start = 1'b1;
    @(negedge clk);
    pulse_start = 1'b0;
  endtask

  task automatic check_level(input string tag);
    check({tag, "_amp"}, int'(amp_level), model_amp);
    check({tag, "_done"}, int'(ramp_done), int'(enable && (model_amp == int'(ramp))));
  endtask

  task automatic pulse_and_check(input string tag);
    do_pulse();
    repeat (30) @(negedge clk);
    check_level(tag);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_for(input int which, input string tag);
    int k;
    k = 0;
    while (((which == 0) ? !sw_cath : !sw_anod) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'((which == 0) ? sw_cath : sw_anod), 1);
  endtask

  initial begin
    resetn = 1'b0;
    pulse_start = 1'b0;
    phase_duration = 3'd2;
    ipg = 3'd0;
    ramp = 6'd10;
    up = 4'd4;
    down = 4'd4;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dac", int'(dac_code), 0);
    check("rst_amp", int'(amp_level), 0);
    check("rst_short", int'(sw_short), 1);
    check("rst_cath", int'(sw_cath), 0);
    check("rst_anod", int'(sw_anod), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    resetn = 1'b1;
    @(negedge clk);

    // ramp up 4, 8, 10, 10 with 3/3/4 cycle phases
    for (int i = 0; i < 4; i++) pulse_and_check("ramp_up");

    // clamp below current level, then large steps hitting the 7-bit sum limit
    ramp = 6'd7;
    pulse_and_check("clamp_low");
    ramp = 6'd63;
    up = 4'd15;
    for (int i = 0; i < 5; i++) pulse_and_check("sat_up");
    ramp = 6'd10;
    up = 4'd4;
    pulse_and_check("clamp_10");

    // inter-phase gap; mid-pulse timing changes apply only to the next pulse
    phase_duration = 3'd1;
    ipg = 3'd3;
    do_pulse();
    repeat (2) @(negedge clk);
    phase_duration = 3'd4;
    ipg = 3'd5;
    wait_idle();
    phase_duration = 3'd0;
    ipg = 3'd7;
    pulse_and_check("gap_max");
    phase_duration = 3'd2;
    ipg = 3'd0;

    // enable dropped mid-pulse: pulse completes at launched amplitude
    do_pulse();
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_idle();
    check_level("en_drop");

    // ramp down 6, 2, then no pulse
    pulse_and_check("ramp_dn");
    pulse_and_check("ramp_dn");
    do_pulse();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dn_zero_busy", int'(busy), 0);
    end
    check_level("dn_zero");

    // overrun during ANOD
    enable = 1'b1;
    do_pulse();
    wait_for(1, "reach_anod");
    pulse_start = 1'b1;
    @(negedge clk);
    pulse_start = 1'b0;
    check("overrun_hi", int'(overrun), 1);
    @(negedge clk);
    check("overrun_lo", int'(overrun), 0);
    wait_idle();
    repeat (10) @(negedge clk);
    check("ovr_no_pulse", int'(busy), 0);
    check_level("ovr");

    // reset in CATH
    do_pulse();
    wait_for(0, "reach_cath");
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_cath", int'(sw_cath), 0);
    check("mid_rst_short", int'(sw_short), 1);
    check("mid_rst_dac", int'(dac_code), 0);
    check("mid_rst_amp", int'(amp_level), 0);
    exp_q.delete();
    pd_q.delete();
    ipg_q.delete();
    model_amp = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    pulse_and_check("post_rst");

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
